// File: rtl/eth_fifo_pkg.sv
// ---------------------------------------------------------------------------
// eth_fifo_pkg
// Shared definitions for the Ethernet receive packet FIFO:
//   - ptr_width()   : pointer width (one wrap bit above the RAM address)
//   - calc_level()  : modulo distance between two pointers
//   - FWFT_OFF/ON   : read-mode selector values for the FWFT parameter
//   - stage_state_e : occupancy of the first-word-fall-through output stage
// ---------------------------------------------------------------------------
package eth_fifo_pkg;

  // Widest pointer the FIFO can use (DEPTH_WIDTH up to 20, plus wrap bit).
  localparam int unsigned MAX_PTR_W = 21;

  typedef logic [MAX_PTR_W-1:0] wide_ptr_t;

  localparam int unsigned FWFT_OFF = 0;
  localparam int unsigned FWFT_ON  = 1;

  typedef enum logic {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_e;

  // The extra wrap bit lets full (distance 2^DEPTH_WIDTH) be told apart
  // from empty (distance 0).
  function automatic int unsigned ptr_width(input int unsigned depth_width);
    return depth_width + 1;
  endfunction

  // Distance head - tail, reduced modulo 2^ptr_w.
  function automatic wide_ptr_t calc_level(input wide_ptr_t   head,
                                           input wide_ptr_t   tail,
                                           input int unsigned ptr_w);
    wide_ptr_t mask;
    mask = wide_ptr_t'((64'd1 << ptr_w) - 64'd1);
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/eth_fifo_ram.sv
// ---------------------------------------------------------------------------
// eth_fifo_ram
// Simple dual-port RAM: one write port, one read port, registered read.
// Ports:
//   clk      : clock
//   rst_n    : async active-low reset, clears only the read register
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write word
//   rd_en    : read strobe; rd_data holds when low
//   rd_addr  : read address
//   rd_data  : registered read word, valid the cycle after rd_en
// ---------------------------------------------------------------------------
module eth_fifo_ram #(
  parameter int unsigned WIDTH  = 33,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // The array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read register is reset so the FIFO presents zero data out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/eth_pkt_fifo.sv
// ---------------------------------------------------------------------------
// eth_pkt_fifo
// Store-and-forward packet FIFO for the Ethernet receive path.
// Words of a frame only become readable once the frame's last word is
// committed. Bad or overflowing frames are discarded by rewinding the write
// pointer to the last commit point.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   wr_data/wr_en    : write word and strobe
//   wr_last          : final word of the frame (qualifies wr_en)
//   wr_bad           : discard the frame (sampled with wr_en & wr_last)
//   wr_full          : no free word
//   almost_full      : wr_water_level >= ALMOST_FULL_NUM
//   wr_water_level   : words stored, committed plus uncommitted
//   pkt_drop         : one-cycle pulse per discarded frame
//   rd_en            : read / pop strobe
//   rd_data/rd_last  : read word and its last-word tag
//   rd_empty         : no committed word available
//   almost_empty     : rd_water_level <= ALMOST_EMPTY_NUM
//   rd_water_level   : committed words not yet popped
// ---------------------------------------------------------------------------
module eth_pkt_fifo
  import eth_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned DEPTH_WIDTH      = 9,
  parameter int unsigned ALMOST_FULL_NUM  = 508,
  parameter int unsigned ALMOST_EMPTY_NUM = 4,
  parameter int unsigned FWFT             = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_bad,
  output logic                  wr_full,
  output logic                  almost_full,
  output logic [DEPTH_WIDTH:0]  wr_water_level,
  output logic                  pkt_drop,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [DEPTH_WIDTH:0]  rd_water_level
);

  localparam int unsigned PW = ptr_width(DEPTH_WIDTH);

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t CAPACITY = ptr_t'(2**DEPTH_WIDTH);
  localparam ptr_t AF_THR   = ptr_t'(ALMOST_FULL_NUM);
  localparam ptr_t AE_THR   = ptr_t'(ALMOST_EMPTY_NUM);

  // rd_ptr is the RAM fetch pointer; in FWFT mode the word sitting in the
  // output stage has already been fetched and is accounted for separately.
  ptr_t wr_ptr;
  ptr_t commit_ptr;
  ptr_t rd_ptr;
  logic ovf;

  stage_state_e stage_state;

  logic              wr_accept;
  logic              frame_end;
  logic              frame_drop;
  logic              committed_avail;
  logic              rd_fire;
  logic              ram_rd_en;
  logic              full_int;
  logic              empty_int;
  ptr_t              wr_level;
  ptr_t              rd_level;
  logic [DATA_WIDTH:0] ram_q;

  // Everything here is decoded from registered pointers; wr_en/rd_en only
  // steer the next-state logic and never reach an output.
  always_comb begin
    wr_level        = ptr_t'(calc_level(wide_ptr_t'(wr_ptr), wide_ptr_t'(rd_ptr), PW));
    full_int        = (wr_level == CAPACITY);
    committed_avail = (commit_ptr != rd_ptr);

    // Once a frame has overflowed its remaining words are ignored, even if
    // the reader frees space meanwhile; the frame is dropped at wr_last.
    wr_accept  = wr_en & ~full_int & ~ovf;
    frame_end  = wr_en & wr_last;
    frame_drop = frame_end & (wr_bad | ovf | ~wr_accept);

    rd_fire   = 1'b0;
    ram_rd_en = 1'b0;
    empty_int = 1'b1;
    rd_level  = ptr_t'(calc_level(wide_ptr_t'(commit_ptr), wide_ptr_t'(rd_ptr), PW));

    if (FWFT == FWFT_ON) begin
      // Refill the output stage when it is empty or being popped, so a
      // back-to-back pop sees the next word with no bubble.
      rd_fire   = rd_en & (stage_state == STAGE_FULL);
      ram_rd_en = committed_avail & ((stage_state == STAGE_EMPTY) | rd_fire);
      empty_int = (stage_state == STAGE_EMPTY);
      rd_level  = rd_level + ptr_t'(stage_state == STAGE_FULL);
    end else begin
      ram_rd_en = rd_en & committed_avail;
      empty_int = ~committed_avail;
    end
  end

  // Write side: a drop rewinds wr_ptr to the commit point, discarding every
  // word of the frame, including one written in this very cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      ovf        <= 1'b0;
      pkt_drop   <= 1'b0;
    end else begin
      pkt_drop <= frame_drop;

      if (frame_drop) begin
        wr_ptr <= commit_ptr;
      end else if (wr_accept) begin
        wr_ptr <= wr_ptr + ptr_t'(1);
      end

      // A non-dropped frame end always accepted its last word.
      if (frame_end && !frame_drop) begin
        commit_ptr <= wr_ptr + ptr_t'(1);
      end

      if (frame_end) begin
        ovf <= 1'b0;
      end else if (wr_en && full_int) begin
        ovf <= 1'b1;
      end
    end
  end

  // Read side: fetch pointer and (FWFT only) output stage occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      stage_state <= STAGE_EMPTY;
    end else begin
      if (ram_rd_en) begin
        rd_ptr <= rd_ptr + ptr_t'(1);
      end

      if (FWFT == FWFT_ON) begin
        if (ram_rd_en) begin
          stage_state <= STAGE_FULL;
        end else if (rd_fire) begin
          stage_state <= STAGE_EMPTY;
        end
      end
    end
  end

  // The RAM read register doubles as the FWFT output stage.
  eth_fifo_ram #(
    .WIDTH  (DATA_WIDTH + 1),
    .ADDR_W (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr[DEPTH_WIDTH-1:0]),
    .wr_data ({wr_last, wr_data}),
    .rd_en   (ram_rd_en),
    .rd_addr (rd_ptr[DEPTH_WIDTH-1:0]),
    .rd_data (ram_q)
  );

  assign rd_data        = ram_q[DATA_WIDTH-1:0];
  assign rd_last        = ram_q[DATA_WIDTH];
  assign wr_full        = full_int;
  assign almost_full    = (wr_level >= AF_THR);
  assign wr_water_level = wr_level;
  assign rd_empty       = empty_int;
  assign almost_empty   = (rd_level <= AE_THR);
  assign rd_water_level = rd_level;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// ---------------------------------------------------------------------------
// tb_eth_pkt_fifo
// Directed bench for eth_pkt_fifo. A standard-read instance is checked by a
// scoreboard (expected words queued when written, popped by a monitor when a
// read completes). A first-word-fall-through instance is checked directly.
// ---------------------------------------------------------------------------
module tb_eth_pkt_fifo;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic [31:0] wr_data;
  logic        wr_en, wr_last, wr_bad, rd_en;
  logic        wr_full, almost_full, pkt_drop, rd_last, rd_empty, almost_empty;
  logic [9:0]  wr_water_level, rd_water_level;
  logic [31:0] rd_data;

  logic [31:0] f_wr_data;
  logic        f_wr_en, f_wr_last, f_wr_bad, f_rd_en;
  logic        f_wr_full, f_almost_full, f_pkt_drop, f_rd_last, f_rd_empty, f_almost_empty;
  logic [9:0]  f_wr_water_level, f_rd_water_level;
  logic [31:0] f_rd_data;

  int   n_compared;
  int   n_mismatched;
  exp_t exp_q[$];
  logic rd_fire_q;

  eth_pkt_fifo #(.FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n),
    .wr_data(wr_data), .wr_en(wr_en), .wr_last(wr_last), .wr_bad(wr_bad),
    .wr_full(wr_full), .almost_full(almost_full), .wr_water_level(wr_water_level),
    .pkt_drop(pkt_drop), .rd_en(rd_en), .rd_data(rd_data), .rd_last(rd_last),
    .rd_empty(rd_empty), .almost_empty(almost_empty), .rd_water_level(rd_water_level)
  );

  eth_pkt_fifo #(.FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n),
    .wr_data(f_wr_data), .wr_en(f_wr_en), .wr_last(f_wr_last), .wr_bad(f_wr_bad),
    .wr_full(f_wr_full), .almost_full(f_almost_full), .wr_water_level(f_wr_water_level),
    .pkt_drop(f_pkt_drop), .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_last(f_rd_last),
    .rd_empty(f_rd_empty), .almost_empty(f_almost_empty), .rd_water_level(f_rd_water_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One clock cycle of stimulus to the selected instance; the other idles.
  // Returns at the following falling edge with outputs settled.
  task automatic applyStimulus(input logic is_fwft, input logic we,
                               input logic [31:0] data, input logic last,
                               input logic bad, input logic re);
    wr_en   = !is_fwft && we;  wr_data   = is_fwft ? 32'h0 : data;
    wr_last = !is_fwft && last; wr_bad   = !is_fwft && bad;  rd_en   = !is_fwft && re;
    f_wr_en   = is_fwft && we; f_wr_data = is_fwft ? data : 32'h0;
    f_wr_last = is_fwft && last; f_wr_bad = is_fwft && bad;  f_rd_en = is_fwft && re;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wr_full"},        32'(wr_full),        32'd0);
    checkOutput({tag, "_almost_full"},    32'(almost_full),    32'd0);
    checkOutput({tag, "_wr_level"},       32'(wr_water_level), 32'd0);
    checkOutput({tag, "_pkt_drop"},       32'(pkt_drop),       32'd0);
    checkOutput({tag, "_rd_data"},        rd_data,             32'd0);
    checkOutput({tag, "_rd_last"},        32'(rd_last),        32'd0);
    checkOutput({tag, "_rd_empty"},       32'(rd_empty),       32'd1);
    checkOutput({tag, "_almost_empty"},   32'(almost_empty),   32'd1);
    checkOutput({tag, "_rd_level"},       32'(rd_water_level), 32'd0);
    checkOutput({tag, "_f_rd_empty"},     32'(f_rd_empty),     32'd1);
    checkOutput({tag, "_f_rd_data"},      f_rd_data,           32'd0);
  endtask

  // Remembers which edges completed a standard-mode read.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_fire_q <= 1'b0;
    else        rd_fire_q <= rd_en && !rd_empty;
  end

  // Scoreboard monitor: a completed read must match the oldest queued word.
  always @(negedge clk) begin
    if (rst_n && rd_fire_q) begin
      if (exp_q.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL sb_underflow: got 0x%0h, expected no read", rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_rd_data", rd_data, e.data);
        checkOutput("sb_rd_last", 32'(rd_last), 32'(e.last));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t        e;
    logic [31:0] d;
    n_compared   = 0;
    n_mismatched = 0;
    wr_en = 0; wr_data = 0; wr_last = 0; wr_bad = 0; rd_en = 0;
    f_wr_en = 0; f_wr_data = 0; f_wr_last = 0; f_wr_bad = 0; f_rd_en = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkReset("rst");
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] 10-word good frame");
    for (int i = 0; i < 10; i++) begin
      d = 32'hFFFF_FFFF - 32'(i);
      e.last = (i == 9); e.data = d;
      exp_q.push_back(e);
      applyStimulus(0, 1, d, i == 9, 0, 0);
      if (i == 4) begin
        checkOutput("t1_mid_rd_empty", 32'(rd_empty), 32'd1);
        checkOutput("t1_mid_wr_level", 32'(wr_water_level), 32'd5);
        checkOutput("t1_mid_rd_level", 32'(rd_water_level), 32'd0);
      end
    end
    checkOutput("t1_wr_level", 32'(wr_water_level), 32'd10);
    checkOutput("t1_rd_level", 32'(rd_water_level), 32'd10);
    checkOutput("t1_rd_empty", 32'(rd_empty), 32'd0);
    checkOutput("t1_almost_empty", 32'(almost_empty), 32'd0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t1_last_data", rd_data, 32'hFFFF_FFF6);
    checkOutput("t1_last_tag", 32'(rd_last), 32'd1);
    checkOutput("t1_end_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("t1_end_almost_empty", 32'(almost_empty), 32'd1);
    checkOutput("t1_end_wr_level", 32'(wr_water_level), 32'd0);

    $display("[TB] 5-word bad frame");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 32'h0BAD_0000 + 32'(i), i == 4, i == 4, 0);
      checkOutput("t2_rd_empty", 32'(rd_empty), 32'd1);
      if (i == 3) begin
        checkOutput("t2_wr_level_mid", 32'(wr_water_level), 32'd4);
        checkOutput("t2_no_drop_mid", 32'(pkt_drop), 32'd0);
      end
    end
    checkOutput("t2_pkt_drop", 32'(pkt_drop), 32'd1);
    checkOutput("t2_wr_level", 32'(wr_water_level), 32'd0);
    checkOutput("t2_rd_level", 32'(rd_water_level), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t2_drop_pulse_end", 32'(pkt_drop), 32'd0);
    checkOutput("t2_rd_empty_after", 32'(rd_empty), 32'd1);

    $display("[TB] 600-word oversize frame");
    for (int k = 1; k <= 600; k++) begin
      applyStimulus(0, 1, 32'(k), k == 600, 0, 0);
      if (k == 507) checkOutput("t3_af_507", 32'(almost_full), 32'd0);
      if (k == 508) checkOutput("t3_af_508", 32'(almost_full), 32'd1);
      if (k == 511) checkOutput("t3_full_511", 32'(wr_full), 32'd0);
      if (k == 512) begin
        checkOutput("t3_full_512", 32'(wr_full), 32'd1);
        checkOutput("t3_level_512", 32'(wr_water_level), 32'd512);
      end
      if (k == 550) begin
        checkOutput("t3_full_550", 32'(wr_full), 32'd1);
        checkOutput("t3_level_550", 32'(wr_water_level), 32'd512);
        checkOutput("t3_rd_empty_550", 32'(rd_empty), 32'd1);
        checkOutput("t3_no_drop_550", 32'(pkt_drop), 32'd0);
      end
    end
    checkOutput("t3_pkt_drop", 32'(pkt_drop), 32'd1);
    checkOutput("t3_wr_level", 32'(wr_water_level), 32'd0);
    checkOutput("t3_wr_full", 32'(wr_full), 32'd0);
    checkOutput("t3_almost_full", 32'(almost_full), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_drop_pulse_end", 32'(pkt_drop), 32'd0);

    $display("[TB] committed frame while streaming a second frame");
    for (int i = 0; i < 3; i++) begin
      d = 32'h0000_A000 + 32'(i);
      e.last = (i == 2); e.data = d;
      exp_q.push_back(e);
      applyStimulus(0, 1, d, i == 2, 0, 0);
    end
    checkOutput("t4_rd_level", 32'(rd_water_level), 32'd3);
    checkOutput("t4_wr_level", 32'(wr_water_level), 32'd3);
    checkOutput("t4_rd_empty", 32'(rd_empty), 32'd0);
    for (int j = 0; j < 5; j++) begin
      d = 32'h0000_B000 + 32'(j);
      e.last = 1'b0; e.data = d;
      exp_q.push_back(e);
      applyStimulus(0, 1, d, 0, 0, 1);
    end
    checkOutput("t4_stream_rd_empty", 32'(rd_empty), 32'd1);
    checkOutput("t4_stream_rd_level", 32'(rd_water_level), 32'd0);
    checkOutput("t4_stream_wr_level", 32'(wr_water_level), 32'd5);
    d = 32'h0000_B005;
    e.last = 1'b1; e.data = d;
    exp_q.push_back(e);
    applyStimulus(0, 1, d, 1, 0, 0);
    checkOutput("t4_commit2_rd_empty", 32'(rd_empty), 32'd0);
    checkOutput("t4_commit2_rd_level", 32'(rd_water_level), 32'd6);
    checkOutput("t4_commit2_wr_level", 32'(wr_water_level), 32'd6);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t4_end_rd_empty", 32'(rd_empty), 32'd1);

    $display("[TB] FWFT single-word frame");
    applyStimulus(1, 1, 32'h1234_5678, 1, 0, 0);
    checkOutput("t5_commit1_rd_empty", 32'(f_rd_empty), 32'd1);
    checkOutput("t5_commit1_rd_level", 32'(f_rd_water_level), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("t5_commit2_rd_empty", 32'(f_rd_empty), 32'd0);
    checkOutput("t5_commit2_rd_data", f_rd_data, 32'h1234_5678);
    checkOutput("t5_commit2_rd_last", 32'(f_rd_last), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("t5_pop_rd_empty", 32'(f_rd_empty), 32'd1);
    checkOutput("t5_pop_rd_level", 32'(f_rd_water_level), 32'd0);

    $display("[TB] FWFT back-to-back pops");
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 32'hF0F0_0000 + 32'(i), i == 2, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) begin
      checkOutput("t5_b2b_rd_empty", 32'(f_rd_empty), 32'd0);
      checkOutput("t5_b2b_rd_data", f_rd_data, 32'hF0F0_0000 + 32'(j));
      checkOutput("t5_b2b_rd_last", 32'(f_rd_last), 32'(j == 2));
      applyStimulus(1, 0, 0, 0, 0, 1);
    end
    checkOutput("t5_b2b_end_rd_empty", 32'(f_rd_empty), 32'd1);

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 2; i++) begin
      d = 32'h0000_00D0 + 32'(i);
      e.last = (i == 1); e.data = d;
      exp_q.push_back(e);
      applyStimulus(0, 1, d, i == 1, 0, 0);
    end
    for (int i = 0; i < 2; i++) applyStimulus(0, 1, 32'h0000_00E0 + 32'(i), 0, 0, 0);
    checkOutput("t6_pre_rd_level", 32'(rd_water_level), 32'd2);
    checkOutput("t6_pre_wr_level", 32'(wr_water_level), 32'd4);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkReset("t6_rst");
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      d = 32'hC0DE_0000 + 32'(i);
      e.last = (i == 3); e.data = d;
      exp_q.push_back(e);
      applyStimulus(0, 1, d, i == 3, 0, 0);
    end
    checkOutput("t6_post_rd_level", 32'(rd_water_level), 32'd4);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1);
    checkOutput("t6_post_rd_empty", 32'(rd_empty), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0);

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
